// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: address width, access-size codes,
// FSM state encodings and the alignment and lane-mask helpers.
package lsu_pkg;

  localparam int ADDR_W_DEFAULT = 16;

  localparam logic [1:0] SIZE_BYTE   = 2'b00;
  localparam logic [1:0] SIZE_HALF   = 2'b01;
  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic [1:0] SIZE_DOUBLE = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CAP  = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      SIZE_HALF:   return offset[0];
      SIZE_WORD:   return |offset[1:0];
      SIZE_DOUBLE: return |offset;
      default:     return 1'b0;
    endcase
  endfunction

  // Byte lanes covered by an access of the given size, before shifting to its offset.
  function automatic logic [7:0] laneMask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 8'h01;
      SIZE_HALF: return 8'h03;
      SIZE_WORD: return 8'h0F;
      default:   return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lanes.sv
// Combinational lane logic: extracts and extends a load lane from a doubleword,
// and merges store data into a doubleword for read-modify-write.
module lsu_lanes
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic        signExt,
  input  logic [63:0] dataRead,
  input  logic [63:0] wdata,
  output logic [63:0] loadData,
  output logic [63:0] mergeData
);

  logic [63:0] shiftedRead;
  logic [63:0] shiftedWrite;
  logic [7:0]  sizeMask;
  logic [7:0]  byteEn;
  logic        signBit;

  assign shiftedRead  = dataRead >> {offset, 3'b000};
  assign shiftedWrite = wdata << {offset, 3'b000};
  assign sizeMask     = laneMask(size);
  // Aligned accesses never shift lanes past byte 7, so truncation is safe.
  assign byteEn       = sizeMask << offset;

  always_comb begin
    signBit = 1'b0;
    case (size)
      SIZE_BYTE: signBit = shiftedRead[7];
      SIZE_HALF: signBit = shiftedRead[15];
      SIZE_WORD: signBit = shiftedRead[31];
      default:   signBit = shiftedRead[63];
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : gLane
      assign loadData[8*gi +: 8]  = sizeMask[gi] ? shiftedRead[8*gi +: 8] : {8{signExt & signBit}};
      assign mergeData[8*gi +: 8] = byteEn[gi] ? shiftedWrite[8*gi +: 8] : dataRead[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit bridging byte/half/word/doubleword accesses onto a
// doubleword-wide memory port with one-cycle read latency.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  output logic              ready,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic [63:0]       rdata,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-4:0] direccion,
  output logic [63:0]       dataWrite,
  output logic              memWr,
  input  logic [63:0]       dataRead
);

  logic [2:0]        stateReg;
  logic [2:0]        stateNext;
  logic [ADDR_W-1:0] addrReg;
  logic [1:0]        sizeReg;
  logic              storeReg;
  logic              signReg;
  logic [63:0]       wdataReg;
  logic [63:0]       wbufReg;
  logic [63:0]       rdataReg;
  logic [63:0]       loadData;
  logic [63:0]       mergeData;
  logic              accept;

  assign accept = req & ready;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE: begin
        if (req) begin
          if (isMisaligned(size, addr[2:0]))         stateNext = ST_ERR;
          else if (is_store && size == SIZE_DOUBLE) stateNext = ST_WR;
          else                                      stateNext = ST_RD;
        end
      end
      ST_RD:   stateNext = ST_CAP;
      ST_CAP:  stateNext = storeReg ? ST_WR : ST_DONE;
      ST_WR:   stateNext = ST_DONE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= ST_IDLE;
      addrReg  <= '0;
      sizeReg  <= SIZE_BYTE;
      storeReg <= 1'b0;
      signReg  <= 1'b0;
      wdataReg <= '0;
      wbufReg  <= '0;
      rdataReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        addrReg  <= addr;
        sizeReg  <= size;
        storeReg <= is_store;
        signReg  <= sign_ext;
        wdataReg <= wdata;
        // A doubleword store skips the read, so its write buffer is the raw data.
        wbufReg  <= wdata;
      end
      if (stateReg == ST_CAP) begin
        if (storeReg) wbufReg  <= mergeData;
        else          rdataReg <= loadData;
      end
    end
  end

  lsu_lanes uLanes (
    .size      (sizeReg),
    .offset    (addrReg[2:0]),
    .signExt   (signReg),
    .dataRead  (dataRead),
    .wdata     (wdataReg),
    .loadData  (loadData),
    .mergeData (mergeData)
  );

  assign ready     = (stateReg == ST_IDLE);
  assign done      = (stateReg == ST_DONE) || (stateReg == ST_ERR);
  assign misalign  = (stateReg == ST_ERR);
  assign memWr     = (stateReg == ST_WR);
  assign dataWrite = memWr ? wbufReg : '0;
  assign rdata     = rdataReg;
  assign direccion = (stateReg == ST_RD || stateReg == ST_CAP || stateReg == ST_WR)
                   ? addrReg[ADDR_W-1:3] : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural doubleword memory.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [12:0] idx;
    logic [63:0] wr;
    logic [63:0] rd;
    int          lat;
    logic        mis;
    int          wrCnt;
  } txnT;

  logic        clk = 1'b0;
  logic        rst_n, req, ready, isStore, signExt, done, misalign, memWr;
  logic [1:0]  size;
  logic [15:0] addr;
  logic [63:0] wdata, rdata, dataWrite, dataRead;
  logic [12:0] direccion;
  logic [63:0] mem [0:8191];

  int          assertCnt = 0, failCnt = 0;
  int          negCnt = 0, acceptNeg = 0, wrCnt = 0, doneCnt = 0;
  logic [63:0] curRdata = '0;
  txnT         sb[$];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .ready     (ready),
    .is_store  (isStore),
    .size      (size),
    .sign_ext  (signExt),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .misalign  (misalign),
    .direccion (direccion),
    .dataWrite (dataWrite),
    .memWr     (memWr),
    .dataRead  (dataRead)
  );

  always @(posedge clk) begin
    dataRead <= mem[direccion];
    if (memWr) mem[direccion] = dataWrite;
  end

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCnt++;
    if (obs !== exp) begin
      failCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] refLoad(input logic [63:0] dw, input int off, input int n, input bit sx);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = dw[8*(off+i) +: 8];
    if (sx && r[8*n-1]) for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [63:0] refMerge(input logic [63:0] dw, input int off, input int n, input logic [63:0] wd);
    logic [63:0] r;
    r = dw;
    for (int i = 0; i < n; i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  function automatic txnT expect_txn(input bit st, input logic [1:0] sz, input bit sx,
                                     input logic [15:0] a, input logic [63:0] wd);
    txnT e;
    int n, off;
    n     = 1 << sz;
    off   = int'(a[2:0]);
    e.idx = a[15:3];
    e.mis = (off % n) != 0;
    e.lat = e.mis ? 1 : (st ? (sz == SIZE_DOUBLE ? 2 : 4) : 3);
    e.wr  = refMerge(mem[a[15:3]], off, n, wd);
    e.wrCnt = (st && !e.mis) ? 1 : 0;
    if (!st && !e.mis) curRdata = refLoad(mem[a[15:3]], off, n, sx);
    e.rd  = curRdata;
    return e;
  endfunction

  // Monitor: pops the scoreboard on every completion pulse.
  always @(negedge clk) begin
    txnT e;
    negCnt++;
    if (memWr) begin
      wrCnt++;
      if (sb.size() == 0) checkVal("memWrWithoutReq", memWr, 0);
      else begin
        checkVal("direccion", direccion, sb[0].idx);
        checkVal("dataWrite", dataWrite, sb[0].wr);
      end
    end
    if (misalign && !done) checkVal("misalignWithoutDone", done, misalign);
    if (done) begin
      doneCnt++;
      if (sb.size() == 0) checkVal("doneWithoutReq", sb.size(), 1);
      else begin
        e = sb.pop_front();
        $display("txn %0d: idx=%h lat=%0d mis=%0b memWr=%0d rdata=%h", doneCnt, e.idx,
                 negCnt - acceptNeg, misalign, wrCnt, rdata);
        checkVal("latency", negCnt - acceptNeg, e.lat);
        checkVal("misalign", misalign, e.mis);
        checkVal("rdata", rdata, e.rd);
        checkVal("memWrCount", wrCnt, e.wrCnt);
      end
      wrCnt = 0;
    end
  end

  task automatic waitReady();
    for (int i = 0; i < 20 && ready !== 1'b1; i++) begin
      @(negedge clk); #1;
    end
    if (ready !== 1'b1) checkVal("readyTimeout", ready, 1);
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 30 && sb.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() > 0) begin
      checkVal("doneTimeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic issue(input bit st, input logic [1:0] sz, input bit sx,
                       input logic [15:0] a, input logic [63:0] wd);
    waitReady();
    isStore = st; size = sz; signExt = sx; addr = a; wdata = wd; req = 1'b1;
    sb.push_back(expect_txn(st, sz, sx, a, wd));
    @(posedge clk);
    acceptNeg = negCnt;
    @(negedge clk); #1;
    req = 1'b0;
    waitIdle();
  endtask

  initial begin
    int prevAcc, base, n, off;
    logic [1:0] sz;
    logic [12:0] idx;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    rst_n = 1'b1; req = 1'b0; isStore = 1'b0; size = SIZE_BYTE; signExt = 1'b0;
    addr = '0; wdata = '0;
    #2 rst_n = 1'b0;
    #1;
    checkVal("rstReady", ready, 1);
    checkVal("rstDone", done, 0);
    checkVal("rstMisalign", misalign, 0);
    checkVal("rstMemWr", memWr, 0);
    checkVal("rstDireccion", direccion, 0);
    checkVal("rstDataWrite", dataWrite, 0);
    checkVal("rstRdata", rdata, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Doubleword store, then RMW byte store into a preloaded doubleword.
    issue(1, SIZE_DOUBLE, 0, 16'hD790, 64'hF);
    checkVal("storeDoubleMem", mem[13'h1AF2], 64'hF);
    mem[13'h1AF2] = 64'h1122334455667788;
    issue(1, SIZE_BYTE, 0, 16'hD793, 64'hCA);
    checkVal("rmwByteMem", mem[13'h1AF2], 64'h11223344CA667788);
    issue(0, SIZE_HALF, 1, 16'hD794, '0);
    checkVal("loadHalfSext", rdata, 64'h0000000000003344);
    issue(1, SIZE_BYTE, 0, 16'hD797, 64'hF0);
    issue(0, SIZE_BYTE, 1, 16'hD797, '0);
    checkVal("loadByteSext", rdata, 64'hFFFFFFFFFFFFFFF0);
    issue(0, SIZE_BYTE, 0, 16'hD797, '0);
    checkVal("loadByteZext", rdata, 64'h00000000000000F0);

    // Misaligned load and store.
    issue(0, SIZE_WORD, 1, 16'hD792, '0);
    checkVal("misalignRdataKept", rdata, 64'h00000000000000F0);
    issue(1, SIZE_HALF, 0, 16'hD791, 64'hBEEF);
    checkVal("misalignNoWrite", mem[13'h1AF2], 64'hF0223344CA667788);

    // Mixed accesses over a few preloaded doublewords.
    for (int i = 0; i < 4; i++) mem[13'h100 + i] = {$urandom, $urandom};
    for (int k = 0; k < 16; k++) begin
      sz  = 2'($urandom_range(0, 3));
      n   = 1 << sz;
      off = $urandom_range(0, 8 / n - 1) * n;
      if ($urandom_range(0, 5) == 0 && sz != SIZE_BYTE) off = off | 1;
      idx = 13'h100 + 13'($urandom_range(0, 3));
      issue($urandom_range(0, 1) == 1, sz, $urandom_range(0, 1) == 1,
            {idx, 3'(off)}, {$urandom, $urandom});
    end

    // Asynchronous reset while the write is on the bus.
    mem[13'h1AF4] = 64'h5555;
    waitReady();
    isStore = 1'b1; size = SIZE_DOUBLE; signExt = 1'b0; addr = 16'hD7A0; wdata = 64'hAAAA;
    req = 1'b1;
    sb.push_back(expect_txn(1, SIZE_DOUBLE, 0, 16'hD7A0, 64'hAAAA));
    @(posedge clk);
    acceptNeg = negCnt;
    @(negedge clk); #1;
    req = 1'b0;
    checkVal("wrBeforeReset", memWr, 1);
    rst_n = 1'b0;
    #1;
    checkVal("rstWrMemWr", memWr, 0);
    checkVal("rstWrReady", ready, 1);
    checkVal("rstWrDataWrite", dataWrite, 0);
    checkVal("rstWrDireccion", direccion, 0);
    checkVal("rstWrRdata", rdata, 0);
    sb.delete();
    wrCnt = 0;
    curRdata = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); #1; end
    checkVal("rstWrMemKept", mem[13'h1AF4], 64'h5555);
    issue(0, SIZE_DOUBLE, 0, 16'hD7A0, '0);
    checkVal("postResetLoad", rdata, 64'h5555);

    // req held high: one access per return to IDLE.
    waitReady();
    isStore = 1'b0; size = SIZE_WORD; signExt = 1'b1; addr = 16'hD794; wdata = '0;
    base = doneCnt;
    prevAcc = 0;
    req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      waitReady();
      sb.push_back(expect_txn(0, SIZE_WORD, 1, 16'hD794, '0));
      @(posedge clk);
      if (k > 0) checkVal("b2bSpacing", negCnt - prevAcc, 4);
      prevAcc = negCnt;
      acceptNeg = negCnt;
      @(negedge clk); #1;
      if (k == 3) req = 1'b0;
    end
    waitIdle();
    repeat (3) begin @(negedge clk); #1; end
    checkVal("b2bDones", doneCnt - base, 4);
    checkVal("b2bRdata", rdata, 64'hFFFFFFFFF0223344);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width; doubleword index = addr[ADDR_W-1:3], 13 bits at default.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  1  access request; sampled only while ready=1.
REQ-005 ready  out  1  unit idle and accepting req.
REQ-006 is_store  in  1  1=store, 0=load.
REQ-007 size  in  2  00 byte, 01 half, 10 word, 11 doubleword.
REQ-008 sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend.
REQ-009 addr  in  ADDR_W  byte address.
REQ-010 wdata  in  64  store data, right-aligned (LSBs).
REQ-011 rdata  out  64  load result, right-aligned, extended.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 misalign  out  1  one-cycle pulse, coincident with done, on misaligned request.
REQ-014 direccion  out  13  doubleword index to DMIO.
REQ-015 dataWrite  out  64  full doubleword to DMIO.
REQ-016 memWr  out  1  DMIO write enable; DMIO writes on rising edge while high.
REQ-017 dataRead  in  64  DMIO read data, valid one cycle after direccion is driven.

Function
REQ-018 On accept (req & ready), addr, size, is_store, sign_ext and wdata SHALL be latched; ready SHALL be 0 from the next cycle until return to IDLE.
REQ-019 FSM states: IDLE, RD, CAP, WR, DONE, ERR; ready=1 only in IDLE.
REQ-020 Misaligned (half addr[0]!=0, word addr[1:0]!=0, double addr[2:0]!=0): IDLE->ERR->IDLE; done=misalign=1 in ERR; memWr never asserted; rdata unchanged.
REQ-021 Load: IDLE->RD->CAP->DONE; done high in the 3rd cycle after acceptance edge.
REQ-022 Doubleword store: IDLE->WR->DONE; dataWrite=wdata; done 2 cycles after acceptance.
REQ-023 Sub-doubleword store: IDLE->RD->CAP->WR->DONE (read-modify-write); done 4 cycles after acceptance.
REQ-024 Byte lanes little-endian: offset o=addr[2:0] selects bits [8o+8*n-1:8o], n=1/2/4/8 bytes.
REQ-025 CAP: load SHALL register extracted, extended lane into rdata; store SHALL register dataRead with the lane replaced by wdata LSBs, all other bytes preserved.
REQ-026 memWr SHALL be 1 exactly one cycle (WR), decoded from state register only; 0 in every other state.
REQ-027 direccion SHALL hold latched addr[ADDR_W-1:3] in RD, CAP, WR; 0 in IDLE, DONE, ERR.
REQ-028 dataWrite SHALL be 0 outside WR.
REQ-029 rdata SHALL hold its value until the next successful load completes; stores do not change it.
REQ-030 req while ready=0 SHALL be ignored, not queued.
REQ-031 DONE/ERR SHALL return to IDLE unconditionally; req in that cycle is ignored.

Reset
REQ-032 rst_n low SHALL force IDLE, ready=1, done=misalign=memWr=0, direccion=0, dataWrite=0, rdata=0, asynchronously.
REQ-033 Reset during WR SHALL drop memWr immediately; the partially performed access is abandoned, no done pulse.
REQ-034 First request accepted on the first rising edge with rst_n high.

Structure
REQ-035 Package lsu_pkg SHALL hold ADDR_W default, size encodings, and state enumeration.
REQ-036 Lane extract/extend and merge logic SHALL be a combinational sub-module lsu_lanes.

Verification
REQ-037 Store double addr=0xD790 wdata=0xF -> direccion=0x1AF2, memWr one cycle, done 2 cycles after accept.
REQ-038 Memory 0x1122334455667788 at index 0x1AF2; store byte 0xCA at 0xD793 -> written 0x11223344CA667788, memWr once.
REQ-039 Same word, load half 0xD794 sign_ext=1 -> rdata=0x0000000000003344; load byte 0xD797 sign_ext=1 with 0xF0 there -> 0xFFFFFFFFFFFFFFF0.
REQ-040 Load word at 0xD792 -> misalign=done=1 one cycle after accept, memWr 0, rdata unchanged.
REQ-041 rst_n low during WR -> memWr 0 same cycle, state IDLE, no done; next request completes normally.
REQ-042 req held high continuously -> back-to-back accesses, each accepted only in IDLE, no queued duplicates.
